udma_uart_rx_buf: RTL

Parametrised, buffered UART receiver for the uDMA UART peripheral, running in the peripheral clock domain between the RX pad and the uDMA RX channel. Unlike the fixed UART front end, it supports runtime-configurable frame format (5–8 data bits, optional even/odd parity, 1 or 2 stop bits) and a baud divider. It buffers characters in a parametrised FIFO and reports per-character, error, and optional idle-timeout events.

---
 rtl/udma_uart_rx_buf.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/udma_uart_rx_buf.sv
// udma_uart_rx_buf: buffered UART receiver with a runtime frame format, a baud divider and a show-ahead RX FIFO.
// The optional idle-timeout event is built only when UDMA_UART_RX_TIMEOUT_EN is defined.
module udma_uart_rx_buf #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int SYNC_STAGES = 2,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 periph_clk_i,
  input  logic                 rstn_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic [1:0]           cfg_bits_i,
  input  logic                 cfg_parity_en_i,
  input  logic                 cfg_parity_odd_i,
  input  logic                 cfg_stop2_i,
  input  logic [7:0]           cfg_timeout_i,
  input  logic                 uart_rx_i,
  output logic [7:0]           data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [LVL_W-1:0]     fifo_level_o,
  output logic                 rx_char_event_o,
  output logic                 err_parity_o,
  output logic                 err_frame_o,
  output logic                 err_overflow_o,
  output logic                 timeout_event_o
);

  // state  | meaning
  // IDLE   | line idle, waiting for a synchronised falling edge
  // START  | waiting for the mid-bit start sample
  // DATA   | shifting in data bits, LSB first
  // PARITY | checking the parity bit
  // STOP   | sampling one or two stop bits
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam int PTR_W = LVL_W - 1;

  state_e               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 rx_prev_q;
  logic                 rx_s, fall;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [1:0]           bits_q, bits_d;
  logic                 par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic                 sample, frame_done;

  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wptr_q, rptr_q;
  logic [LVL_W-1:0]     level_q;
  logic                 full, pop, push, good;
  logic                 char_q, perr_q, ferr_q, ovf_q;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_prev_q & ~rx_s;

  always_ff @(posedge periph_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
      rx_prev_q <= rx_s;
    end
  end

  always_ff @(posedge periph_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      bits_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bits_q     <= bits_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    bits_d     = bits_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    frame_done = 1'b0;
    sample     = (cnt_q == '0);

    if (state_q != IDLE) begin
      cnt_d = sample ? div_q : cnt_q - DIV_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (cfg_en_i && fall) begin
          // Frame format is frozen here so mid-frame cfg writes cannot corrupt it.
          state_d    = START;
          div_d      = cfg_div_i;
          cnt_d      = cfg_div_i >> 1;
          bits_d     = cfg_bits_i;
          par_en_d   = cfg_parity_en_i;
          par_odd_d  = cfg_parity_odd_i;
          stop2_d    = cfg_stop2_i;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          shift_d    = '0;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
        end
      end
      START: begin
        if (sample) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == ({1'b0, bits_q} + 3'd4)) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (sample) begin
          if ((^shift_q ^ rx_s) != par_odd_q) par_err_d = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          if (!rx_s) frm_err_d = 1'b1;
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d    = IDLE;
            frame_done = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!cfg_en_i) begin
      state_d    = IDLE;
      frame_done = 1'b0;
    end
  end

  // Frame outcome priority: frame error, then parity error, then overflow.
  assign valid_o = (level_q != '0);
  assign full    = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop     = valid_o & ready_i;
  assign good    = frame_done & ~frm_err_d & ~par_err_q;
  assign push    = good & (~full | pop);

  always_ff @(posedge periph_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      char_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      char_q <= push;
      perr_q <= frame_done & ~frm_err_d & par_err_q;
      ferr_q <= frame_done & frm_err_d;
      ovf_q  <= good & full & ~pop;
    end
  end

  always_ff @(posedge periph_clk_i) begin
    if (push) mem_q[wptr_q] <= shift_q;
  end

  always_ff @(posedge periph_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  assign data_o          = valid_o ? mem_q[rptr_q] : 8'h00;
  assign fifo_level_o    = level_q;
  assign rx_char_event_o = char_q;
  assign err_parity_o    = perr_q;
  assign err_frame_o     = ferr_q;
  assign err_overflow_o  = ovf_q;

`ifdef UDMA_UART_RX_TIMEOUT_EN
  logic [DIV_WIDTH-1:0] tdiv_q;
  logic [7:0]           tcnt_q;
  logic                 to_q;
  logic                 tclr, tick;

  assign tclr = (state_q == IDLE && cfg_en_i && fall) | push | ~valid_o;
  assign tick = (state_q == IDLE) && (tdiv_q == cfg_div_i);

  // Counts whole bit periods of line idle; saturates so it fires once per arm.
  always_ff @(posedge periph_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tdiv_q <= '0;
      tcnt_q <= '0;
      to_q   <= 1'b0;
    end else if (tclr) begin
      tdiv_q <= '0;
      tcnt_q <= '0;
      to_q   <= 1'b0;
    end else begin
      to_q <= 1'b0;
      if (state_q == IDLE) begin
        if (tick) begin
          tdiv_q <= '0;
          if (tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 8'd1;
          if (cfg_timeout_i != 8'd0 && (tcnt_q + 8'd1) == cfg_timeout_i) to_q <= 1'b1;
        end else begin
          tdiv_q <= tdiv_q + DIV_WIDTH'(1);
        end
      end
    end
  end

  assign timeout_event_o = to_q;
`else
  logic unused_timeout;
  assign unused_timeout  = ^cfg_timeout_i;
  assign timeout_event_o = 1'b0;
`endif

endmodule
